add_accum_ctrl: RTL and testbench
=================================

// Module: add_accum_ctrl
// PURPOSE
//  Multi-operand summation controller wrapped around the 8-bit combinational ADD stage.
//  - Upstream of ADD: drives its A input (running accumulator) and its B input (incoming operand).
//  - Downstream of ADD: captures its Y result back into the accumulator.
//  - Accepts COUNT operands over a valid/ready stream, then reports SUM, a sticky unsigned-wrap flag OVF, and a 1-cycle DONE.
// PARAMETERS
//  WIDTH  8  operand/sum width; must equal the width of the ADD instance
//  CNT_W  4  width of COUNT and the internal remaining-operand counter (max 15 operands)
// PORTS
//  CLK       in   1      single clock, rising edge
//  RST_N     in   1      reset, asynchronous assert, active-low
//  START     in   1      start a summation; sampled only in IDLE
//  COUNT     in   CNT_W  number of operands; sampled with START
//  ABORT     in   1      cancel the run in progress
//  IN_VALID  in   1      operand valid
//  IN_DATA   in   WIDTH  operand value
//  IN_READY  out  1      block accepts an operand this cycle
//  ADD_A     out  WIDTH  to ADD.A
//  ADD_B     out  WIDTH  to ADD.B
//  ADD_Y     in   WIDTH  from ADD.Y
//  SUM       out  WIDTH  last completed sum; held until the next completion
//  OVF       out  1      result of the last completed run wrapped mod 2^WIDTH
//  BUSY      out  1      run in progress (state ACCUM)
//  DONE      out  1      1-cycle pulse; SUM/OVF valid from this cycle on
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=IDLE; acc, rem, SUM, OVF, DONE, BUSY, IN_READY = 0.
//  - States: IDLE, ACCUM, FIN.
//  - IDLE:
//    - START & COUNT!=0 & !ABORT -> ACCUM; acc<=0, ovf_r<=0, rem<=COUNT.
//    - START & COUNT==0 & !ABORT -> FIN; acc<=0, ovf_r<=0.
//    - ABORT has priority over START.
//  - ACCUM:
//    - IN_READY=1, BUSY=1.
//    - Handshake = IN_VALID & IN_READY: acc<=ADD_Y; ovf_r<=ovf_r | (ADD_Y<acc); rem<=rem-1.
//    - Wrap rule: unsigned compare; a result smaller than the old acc means the add wrapped.
//    - rem==1 at the handshake -> FIN. Otherwise stay in ACCUM.
//    - IN_VALID low: hold state, no change to acc or rem.
//    - ABORT (with or without a handshake in the same cycle) -> IDLE. acc is discarded; SUM/OVF keep their old values; no DONE.
//  - FIN (exactly 1 cycle): SUM<=acc, OVF<=ovf_r registered on entry, DONE=1 -> IDLE.
//    - ABORT and START are ignored in FIN.
//  - Latency: DONE is high the cycle after the last handshake. COUNT==0 gives DONE 1 cycle after START.
//  - Back-to-back: a START held high in the cycle after DONE begins a new run.
//  - Outside ACCUM: IN_READY=0 and IN_VALID is ignored.
//  - ADD_A = acc always. ADD_B = IN_DATA in ACCUM, 0 otherwise.
//  - All arithmetic is mod 2^WIDTH; no saturation.
//  - START while BUSY is ignored; COUNT is not resampled.
//  - Reset mid-run: immediate return to the reset values, no DONE.
// STRUCTURE
//  - Shared include add_defs.vh: WIDTH default, state encodings (IDLE=2'd0, ACCUM=2'd1, FIN=2'd2).
//  - Sub-module op_counter: loadable CNT_W down-counter; load, dec, is_one outputs.
//  - ADD is instantiated beside this block at the parent level: ADD_A->A, ADD_B->B, Y->ADD_Y.
// TESTING (bench instantiates ADD + add_accum_ctrl)
//  1. COUNT=3; operands 10,20,30 with IN_VALID always high -> SUM=60, OVF=0, DONE 1 cycle after the 3rd handshake, BUSY high 3 cycles.
//  2. COUNT=2; operands 200,100 -> SUM=44, OVF=1. Next run COUNT=1, operand 5 -> SUM=5, OVF=0 (sticky flag cleared per run).
//  3. COUNT=0 -> DONE 1 cycle after START, SUM=0, OVF=0, IN_READY never high.
//  4. COUNT=4; operands 1,2,3,4 with 2-cycle IN_VALID gaps, plus START pulses while BUSY -> SUM=10, exactly one DONE, COUNT change ignored.
//  5. After test 1, COUNT=3, send 7 then assert ABORT -> no DONE, SUM stays 60, BUSY=0 next cycle; START+ABORT together in IDLE -> stays IDLE.
//  6. Drop RST_N mid-run between clock edges -> SUM, OVF, BUSY, IN_READY read 0 before the next edge; state=IDLE after release.

Source files
------------

// File: rtl/add_accum_ctrl_pkg.sv
// Shared types and defaults for the multi-operand summation controller.
// State encodings are fixed because other tooling decodes them.
package add_accum_ctrl_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCntW  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StFin   = 2'd2
  } state_e;

endpackage

// File: rtl/add_accum_ctrl_if.sv
// Operand stream, command, adder and result signals of the summation controller.
interface add_accum_ctrl_if
  import add_accum_ctrl_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned CntW  = DefCntW
);

  logic             start;
  logic [CntW-1:0]  count;
  logic             abort;
  logic             in_valid;
  logic [Width-1:0] in_data;
  logic             in_ready;
  logic [Width-1:0] add_a;
  logic [Width-1:0] add_b;
  logic [Width-1:0] add_y;
  logic [Width-1:0] sum;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, count, abort, in_valid, in_data, add_y,
    input  in_ready, add_a, add_b, sum, ovf, busy, done
  );

  modport slave (
    input  start, count, abort, in_valid, in_data, add_y,
    output in_ready, add_a, add_b, sum, ovf, busy, done
  );

endinterface

// File: rtl/add_accum_ctrl_add.sv
// Combinational ADD stage placed beside the controller; sum wraps mod 2^Width.
module add_accum_ctrl_add #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/add_accum_ctrl_op_counter.sv
// Loadable down-counter tracking operands still to be accepted in a run.
module add_accum_ctrl_op_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            dec,
  input  logic [CntW-1:0] load_val,
  output logic            is_one
);

  logic [CntW-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load) begin
      rem_d = load_val;
    end else if (dec) begin
      rem_d = rem_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign is_one = (rem_q == CntW'(1));

endmodule

// File: rtl/add_accum_ctrl.sv
// Summation controller: feeds the external adder, accumulates COUNT operands,
// then publishes SUM/OVF with a 1-cycle DONE.
module add_accum_ctrl
  import add_accum_ctrl_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned CntW  = DefCntW
) (
  input logic             clk,
  input logic             rst_n,
  add_accum_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [Width-1:0] acc_q, acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [Width-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic             in_accum;

  add_accum_ctrl_op_counter #(
    .CntW (CntW)
  ) u_op_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (bus.count),
    .is_one   (cnt_is_one)
  );

  assign in_accum = (state_q == StAccum);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          if (bus.count != '0) begin
            state_d  = StAccum;
            cnt_load = 1'b1;
          end else begin
            state_d = StFin;
            sum_d   = '0;
            ovf_d   = 1'b0;
          end
        end
      end
      StAccum: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.in_valid) begin
          acc_d     = bus.add_y;
          // A result below the old accumulator means the add wrapped.
          ovf_acc_d = ovf_acc_q | (bus.add_y < acc_q);
          cnt_dec   = 1'b1;
          if (cnt_is_one) begin
            state_d = StFin;
            sum_d   = bus.add_y;
            ovf_d   = ovf_acc_d;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready = in_accum;
  assign bus.busy     = in_accum;
  assign bus.done     = (state_q == StFin);
  assign bus.add_a    = acc_q;
  assign bus.add_b    = in_accum ? bus.in_data : '0;
  assign bus.sum      = sum_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_add_accum_ctrl.sv
// Directed bench: ADD stage plus add_accum_ctrl, expected values hand-computed.
module tb_add_accum_ctrl;

  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  add_accum_ctrl_if #(.Width(8), .CntW(4)) bus ();

  add_accum_ctrl_add #(
    .Width (8)
  ) u_add (
    .a (bus.add_a),
    .b (bus.add_b),
    .y (bus.add_y)
  );

  add_accum_ctrl #(
    .Width (8),
    .CntW  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.count    = 4'd0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    #12;
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: 10+20+30
    bus.start = 1'b1; bus.count = 4'd3;
    tick();
    bus.start = 1'b0;
    chk("t1_busy0", 32'(bus.busy), 32'd1);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 8'd10;
    #1;
    chk("t1_add_a0", 32'(bus.add_a), 32'd0);
    chk("t1_add_b", 32'(bus.add_b), 32'd10);
    tick();
    chk("t1_busy1", 32'(bus.busy), 32'd1);
    chk("t1_acc1", 32'(bus.add_a), 32'd10);
    bus.in_data = 8'd20;
    tick();
    chk("t1_busy2", 32'(bus.busy), 32'd1);
    chk("t1_done_early", 32'(bus.done), 32'd0);
    bus.in_data = 8'd30;
    tick();
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_sum", 32'(bus.sum), 32'd60);
    chk("t1_ovf", 32'(bus.ovf), 32'd0);
    chk("t1_busy_fin", 32'(bus.busy), 32'd0);
    chk("t1_ready_fin", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);

    // 5: abort after one operand, then START+ABORT in idle
    bus.start = 1'b1; bus.count = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd7;
    tick();
    chk("t5_acc", 32'(bus.add_a), 32'd7);
    bus.abort = 1'b1; bus.in_data = 8'd9;
    tick();
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_sum", 32'(bus.sum), 32'd60);
    chk("t5_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    tick();
    chk("t5_sa_busy", 32'(bus.busy), 32'd0);
    chk("t5_sa_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    chk("t5_sa_done2", 32'(bus.done), 32'd0);
    chk("t5_sum2", 32'(bus.sum), 32'd60);

    // 2: 200+100 wraps to 44, then a clean run clears the flag
    bus.start = 1'b1; bus.count = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd200;
    tick();
    chk("t2_acc", 32'(bus.add_a), 32'd200);
    bus.in_data = 8'd100;
    tick();
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_sum", 32'(bus.sum), 32'd44);
    chk("t2_ovf", 32'(bus.ovf), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b1; bus.count = 4'd1;
    tick();
    bus.start = 1'b0;
    chk("t2b_ovf_held", 32'(bus.ovf), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 8'd5;
    tick();
    chk("t2b_done", 32'(bus.done), 32'd1);
    chk("t2b_sum", 32'(bus.sum), 32'd5);
    chk("t2b_ovf", 32'(bus.ovf), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // 3: zero operands
    bus.start = 1'b1; bus.count = 4'd0;
    bus.in_valid = 1'b1; bus.in_data = 8'd99;
    tick();
    bus.start = 1'b0;
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_sum", 32'(bus.sum), 32'd0);
    chk("t3_ovf", 32'(bus.ovf), 32'd0);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_add_b", 32'(bus.add_b), 32'd0);
    tick();
    chk("t3_done_pulse", 32'(bus.done), 32'd0);
    chk("t3_ready2", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // 4: gapped operands with START/COUNT noise while busy
    bus.start = 1'b1; bus.count = 4'd4;
    tick();
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b0;
      bus.start = 1'b1; bus.count = 4'd7;
      tick();
      chk("t4_gap_busy", 32'(bus.busy), 32'd1);
      chk("t4_gap_done", 32'(bus.done), 32'd0);
      tick();
      chk("t4_gap_done2", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      tick();
    end
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_sum", 32'(bus.sum), 32'd10);
    chk("t4_ovf", 32'(bus.ovf), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("t4_done_once", 32'(bus.done), 32'd0);
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // 6: asynchronous reset mid-run
    bus.start = 1'b1; bus.count = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd50;
    tick();
    chk("t6_pre_busy", 32'(bus.busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_sum", 32'(bus.sum), 32'd0);
    chk("t6_ovf", 32'(bus.ovf), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_acc", 32'(bus.add_a), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);
    chk("t6_idle_done", 32'(bus.done), 32'd0);
    chk("t6_idle_acc", 32'(bus.add_a), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
